// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the 5-stage MIPS pipeline stage registers.
//
// Contents:
//   RESET_PC        pc loaded into every stage register on reset
//   GPR_W           GPR index width
//   TNEW_W          width of the Tnew hazard field
//   exc_code_e      CP0 ExcCode values the pipeline can raise
//   PL_*            field offsets/widths used by each stage to pack and
//                   unpack the opaque payload bus
//
// The stage register never interprets the payload; the offsets live here so
// the producing and consuming stages agree on a single layout.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam int          GPR_W    = 5;
   localparam int          TNEW_W   = 3;

   typedef enum logic [4:0] {
      EXC_INT  = 5'd0,
      EXC_ADEL = 5'd4,
      EXC_ADES = 5'd5,
      EXC_RI   = 5'd10,
      EXC_OV   = 5'd12
   } exc_code_e;

   // Payload layout (128-bit bus): two operands, the stage result and a
   // block of decoded control bits.
   localparam int PL_DATA_W     = 128;
   localparam int PL_SRC_A_LSB  = 0;
   localparam int PL_SRC_A_W    = 32;
   localparam int PL_SRC_B_LSB  = 32;
   localparam int PL_SRC_B_W    = 32;
   localparam int PL_RESULT_LSB = 64;
   localparam int PL_RESULT_W   = 32;
   localparam int PL_CTRL_LSB   = 96;
   localparam int PL_CTRL_W     = 32;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Bundles the control, upstream (in_*) and downstream (out_*) signals of a
// pipeline stage register.
//
// Modports:
//   master  the surrounding pipeline: drives stall_i, flush_i and in_*,
//           observes out_*
//   slave   the stage register itself: observes stall_i, flush_i and in_*,
//           drives out_*
//
// Signals:
//   stall_i, flush_i                       hold / bubble control
//   in_valid, in_pc, in_wr, in_regwrite,
//   in_tnew, in_payload                    upstream stage contents
//   out_valid, out_pc, out_wr, out_regwrite,
//   out_tnew, out_payload, out_fwd_ok      registered stage contents
//
// Optional macro PIPE_STAGE_EXC_EN adds in_exccode, in_bd, stage_exccode,
// out_exccode and out_bd.
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int DATA_W = 128,
   parameter int TNEW_W = pipe_pkg::TNEW_W
);
   import pipe_pkg::*;

   logic              stall_i;
   logic              flush_i;

   logic              in_valid;
   logic [31:0]       in_pc;
   logic [GPR_W-1:0]  in_wr;
   logic              in_regwrite;
   logic [TNEW_W-1:0] in_tnew;
   logic [DATA_W-1:0] in_payload;

   logic              out_valid;
   logic [31:0]       out_pc;
   logic [GPR_W-1:0]  out_wr;
   logic              out_regwrite;
   logic [TNEW_W-1:0] out_tnew;
   logic [DATA_W-1:0] out_payload;
   logic              out_fwd_ok;

`ifdef PIPE_STAGE_EXC_EN
   logic [4:0]        in_exccode;
   logic              in_bd;
   logic [4:0]        stage_exccode;
   logic [4:0]        out_exccode;
   logic              out_bd;
`endif

   modport master (
`ifdef PIPE_STAGE_EXC_EN
      output in_exccode, in_bd, stage_exccode,
      input  out_exccode, out_bd,
`endif
      output stall_i, flush_i,
      output in_valid, in_pc, in_wr, in_regwrite, in_tnew, in_payload,
      input  out_valid, out_pc, out_wr, out_regwrite, out_tnew, out_payload,
      input  out_fwd_ok
   );

   modport slave (
`ifdef PIPE_STAGE_EXC_EN
      input  in_exccode, in_bd, stage_exccode,
      output out_exccode, out_bd,
`endif
      input  stall_i, flush_i,
      input  in_valid, in_pc, in_wr, in_regwrite, in_tnew, in_payload,
      output out_valid, out_pc, out_wr, out_regwrite, out_tnew, out_payload,
      output out_fwd_ok
   );

endinterface

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// -----------------------------------------------------------------------------
// tnew_sat_dec
// Combinational saturating subtractor for the Tnew hazard field.
//
// Ports:
//   stored  in  TNEW_W  Tnew value held in the stage register
//   result  out TNEW_W  stored - TNEW_DEC, clamped at zero
//
// TNEW_DEC = 0 turns the block into a pass-through.
// -----------------------------------------------------------------------------
module tnew_sat_dec #(
   parameter int TNEW_W   = pipe_pkg::TNEW_W,
   parameter int TNEW_DEC = 1
) (
   input  logic [TNEW_W-1:0] stored,
   output logic [TNEW_W-1:0] result
);
   import pipe_pkg::*;

   // The comparison is done in int so a decrement larger than the field
   // can hold still clamps to zero instead of wrapping.
   always_comb begin
      result = '0;
      if (int'(stored) >= TNEW_DEC) begin
         result = stored - TNEW_W'(TNEW_DEC);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register (D/E, E/M, M/W) for the 5-stage MIPS core.
// Carries an opaque payload plus the hazard fields pc, write register,
// RegWrite and Tnew, with stall, flush, a valid bit, a saturating Tnew
// countdown and a forwarding-ready flag.
//
// Ports:
//   clk     in   clock, all state updates on the rising edge
//   reset   in   synchronous, active-high reset
//   bus     pipe_stage_reg_if.slave
//             stall_i, flush_i, in_* observed; out_* driven
//
// Edge priority: reset > flush_i > stall_i > load. A load of an instruction
// with in_valid low stores the same bubble a flush would.
//
// Optional macro PIPE_STAGE_EXC_EN adds an ExcCode and branch-delay bit to
// the stage; the default build has neither.
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int          DATA_W   = 128,
   parameter int          TNEW_W   = pipe_pkg::TNEW_W,
   parameter logic [31:0] RESET_PC = pipe_pkg::RESET_PC,
   parameter int          TNEW_DEC = 1
) (
   input logic              clk,
   input logic              reset,
   pipe_stage_reg_if.slave  bus
);
   import pipe_pkg::*;

   logic              stored_valid;
   logic [31:0]       stored_pc;
   logic [GPR_W-1:0]  stored_wr;
   logic              stored_regwrite;
   logic [TNEW_W-1:0] stored_tnew;
   logic [DATA_W-1:0] stored_payload;
   logic [TNEW_W-1:0] tnew_dec;

   // A flush and a load with in_valid low both store a bubble; only the pc
   // (and the bd bit when exceptions are enabled) follow the input so that
   // the bubble still carries a meaningful address downstream.
   logic bubble;
   assign bubble = bus.flush_i | (~bus.stall_i & ~bus.in_valid);

   // Hazard and payload state.
   always_ff @(posedge clk) begin
      if (reset) begin
         stored_valid    <= 1'b0;
         stored_pc       <= RESET_PC;
         stored_wr       <= '0;
         stored_regwrite <= 1'b0;
         stored_tnew     <= '0;
         stored_payload  <= '0;
      end else if (bubble) begin
         stored_valid    <= 1'b0;
         stored_pc       <= bus.in_pc;
         stored_wr       <= '0;
         stored_regwrite <= 1'b0;
         stored_tnew     <= '0;
         stored_payload  <= '0;
      end else if (!bus.stall_i) begin
         stored_valid    <= 1'b1;
         stored_pc       <= bus.in_pc;
         stored_wr       <= bus.in_wr;
         stored_regwrite <= bus.in_regwrite;
         stored_tnew     <= bus.in_tnew;
         stored_payload  <= bus.in_payload;
      end
   end

   // Tnew is decremented on the output side so a held instruction keeps a
   // stable Tnew for the whole stall.
   tnew_sat_dec #(
      .TNEW_W   (TNEW_W),
      .TNEW_DEC (TNEW_DEC)
   ) u_tnew_sat_dec (
      .stored (stored_tnew),
      .result (tnew_dec)
   );

   assign bus.out_valid    = stored_valid;
   assign bus.out_pc       = stored_pc;
   assign bus.out_wr       = stored_wr;
   assign bus.out_regwrite = stored_regwrite & stored_valid;
   assign bus.out_tnew     = tnew_dec;
   assign bus.out_payload  = stored_payload;

   // Forwarding from $0 is never allowed, and the value must already exist.
   assign bus.out_fwd_ok   = stored_valid & stored_regwrite
                           & (stored_wr != '0) & (tnew_dec == '0);

`ifdef PIPE_STAGE_EXC_EN
   logic [4:0] stored_exccode;
   logic       stored_bd;

   // An exception already recorded upstream is older than one raised in
   // this stage, so a nonzero in_exccode takes precedence.
   always_ff @(posedge clk) begin
      if (reset) begin
         stored_exccode <= EXC_INT;
         stored_bd      <= 1'b0;
      end else if (bubble) begin
         stored_exccode <= EXC_INT;
         stored_bd      <= bus.in_bd;
      end else if (!bus.stall_i) begin
         stored_exccode <= (bus.in_exccode != 5'd0) ? bus.in_exccode
                                                    : bus.stage_exccode;
         stored_bd      <= bus.in_bd;
      end
   end

   assign bus.out_exccode = stored_exccode;
   assign bus.out_bd      = stored_bd;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Self-checking bench for pipe_stage_reg: a table of directed per-cycle
// vectors, hand-written stall/flush and exception sequences, then a random
// run checked against a behavioural model of the stage.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam int          TB_DATA_W   = 128;
   localparam int          TB_TNEW_W   = 3;
   localparam int          TB_TNEW_DEC = 1;
   localparam logic [31:0] TB_RESET_PC = 32'h0000_3000;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   pipe_stage_reg_if #(.DATA_W(TB_DATA_W), .TNEW_W(TB_TNEW_W)) bus ();

   pipe_stage_reg #(
      .DATA_W   (TB_DATA_W),
      .TNEW_W   (TB_TNEW_W),
      .RESET_PC (TB_RESET_PC),
      .TNEW_DEC (TB_TNEW_DEC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         rst;
      logic         flush;
      logic         stall;
      logic         valid;
      logic [31:0]  pc;
      logic [4:0]   wr;
      logic         regwrite;
      logic [2:0]   tnew;
      logic [127:0] payload;
      logic         e_valid;
      logic [31:0]  e_pc;
      logic [4:0]   e_wr;
      logic         e_regwrite;
      logic [2:0]   e_tnew;
      logic         e_fwd;
      logic [127:0] e_payload;
   } vec_t;

   // Behavioural view of what the stage currently holds.
   typedef struct {
      logic         valid;
      logic [31:0]  pc;
      logic [4:0]   wr;
      logic         regwrite;
      logic [2:0]   tnew;
      logic [127:0] payload;
   } stage_t;

   vec_t   vecs[$];
   stage_t model;

   // Drives one cycle of inputs, lets one rising edge pass and settles
   // just after it so outputs are sampled away from the edge.
   task automatic applyStimulus(input logic rst, input logic flush,
                                input logic stall, input logic valid,
                                input logic [31:0] pc, input logic [4:0] wr,
                                input logic regwrite, input logic [2:0] tnew,
                                input logic [127:0] payload);
      reset           = rst;
      bus.flush_i     = flush;
      bus.stall_i     = stall;
      bus.in_valid    = valid;
      bus.in_pc       = pc;
      bus.in_wr       = wr;
      bus.in_regwrite = regwrite;
      bus.in_tnew     = tnew;
      bus.in_payload  = payload;
      @(posedge clk);
      #1;
   endtask

   task automatic checkField(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string tag, input logic e_valid,
                              input logic [31:0] e_pc, input logic [4:0] e_wr,
                              input logic e_regwrite, input logic [2:0] e_tnew,
                              input logic e_fwd, input logic [127:0] e_payload);
      checkField({tag, ".valid"},    128'(bus.out_valid),    128'(e_valid));
      checkField({tag, ".pc"},       128'(bus.out_pc),       128'(e_pc));
      checkField({tag, ".wr"},       128'(bus.out_wr),       128'(e_wr));
      checkField({tag, ".regwrite"}, 128'(bus.out_regwrite), 128'(e_regwrite));
      checkField({tag, ".tnew"},     128'(bus.out_tnew),     128'(e_tnew));
      checkField({tag, ".fwd_ok"},   128'(bus.out_fwd_ok),   128'(e_fwd));
      checkField({tag, ".payload"},  bus.out_payload,        e_payload);
   endtask

   function automatic vec_t mkVec(logic rst, logic flush, logic stall,
                                  logic valid, logic [31:0] pc, logic [4:0] wr,
                                  logic regwrite, logic [2:0] tnew,
                                  logic [127:0] payload, logic e_valid,
                                  logic [31:0] e_pc, logic [4:0] e_wr,
                                  logic e_regwrite, logic [2:0] e_tnew,
                                  logic e_fwd, logic [127:0] e_payload);
      vec_t v;
      v.rst = rst;        v.flush = flush;       v.stall = stall;
      v.valid = valid;    v.pc = pc;             v.wr = wr;
      v.regwrite = regwrite; v.tnew = tnew;      v.payload = payload;
      v.e_valid = e_valid; v.e_pc = e_pc;        v.e_wr = e_wr;
      v.e_regwrite = e_regwrite; v.e_tnew = e_tnew; v.e_fwd = e_fwd;
      v.e_payload = e_payload;
      return v;
   endfunction

   // Reference rules: reset clears, flush or an invalid load stores a bubble
   // that keeps only the pc, stall holds, otherwise everything loads.
   task automatic modelStep(input logic rst, input logic flush,
                            input logic stall, input logic valid,
                            input logic [31:0] pc, input logic [4:0] wr,
                            input logic regwrite, input logic [2:0] tnew,
                            input logic [127:0] payload);
      if (rst) begin
         model = '{valid: 1'b0, pc: TB_RESET_PC, wr: 5'd0, regwrite: 1'b0,
                   tnew: 3'd0, payload: '0};
      end else if (flush || (!stall && !valid)) begin
         model = '{valid: 1'b0, pc: pc, wr: 5'd0, regwrite: 1'b0,
                   tnew: 3'd0, payload: '0};
      end else if (!stall) begin
         model = '{valid: 1'b1, pc: pc, wr: wr, regwrite: regwrite,
                   tnew: tnew, payload: payload};
      end
   endtask

   task automatic checkModel(input string tag);
      int       t;
      logic [2:0] e_tnew;
      logic     e_rw;
      logic     e_fwd;
      t      = int'(model.tnew) - TB_TNEW_DEC;
      e_tnew = (t < 0) ? 3'd0 : 3'(t);
      e_rw   = model.regwrite && model.valid;
      e_fwd  = e_rw && (model.wr != 5'd0) && (e_tnew == 3'd0);
      checkOutput(tag, model.valid, model.pc, model.wr, e_rw, e_tnew, e_fwd,
                  model.payload);
   endtask

   initial begin
      logic [127:0] ones;
      checks = 0;
      errors = 0;
      ones   = '1;
      reset  = 1'b1;
      bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.in_valid = 1'b0;
      bus.in_pc = '0; bus.in_wr = '0; bus.in_regwrite = 1'b0;
      bus.in_tnew = '0; bus.in_payload = '0;
`ifdef PIPE_STAGE_EXC_EN
      bus.in_exccode = 5'd0; bus.in_bd = 1'b0; bus.stage_exccode = 5'd0;
`endif
      @(negedge clk);

      // ---------------- directed vector table ----------------
      //                rst fl st va pc           wr  rw tn payload
      //                ev  epc          ewr erw et ef epayload
      vecs.push_back(mkVec(1,0,0,1, 32'hdead_beef, 31, 1, 5, ones,
                           0, 32'h3000, 0, 0, 0, 0, '0));
      vecs.push_back(mkVec(1,0,1,1, 32'h0000_1234, 17, 1, 3, ones,
                           0, 32'h3000, 0, 0, 0, 0, '0));
      vecs.push_back(mkVec(0,0,0,1, 32'h3004, 8, 1, 2, 128'h1111,
                           1, 32'h3004, 8, 1, 1, 0, 128'h1111));
      vecs.push_back(mkVec(0,0,0,1, 32'h3008, 8, 1, 1, 128'h2222,
                           1, 32'h3008, 8, 1, 0, 1, 128'h2222));
      vecs.push_back(mkVec(0,0,0,1, 32'h3010, 9, 1, 3, 128'h3333,
                           1, 32'h3010, 9, 1, 2, 0, 128'h3333));
      vecs.push_back(mkVec(0,0,1,1, 32'h3014, 10, 0, 0, 128'haaaa,
                           1, 32'h3010, 9, 1, 2, 0, 128'h3333));
      vecs.push_back(mkVec(0,0,1,0, 32'h3018, 11, 1, 7, 128'hbbbb,
                           1, 32'h3010, 9, 1, 2, 0, 128'h3333));
      vecs.push_back(mkVec(0,0,1,1, 32'h301c, 12, 1, 1, 128'hcccc,
                           1, 32'h3010, 9, 1, 2, 0, 128'h3333));
      vecs.push_back(mkVec(0,0,0,1, 32'h3018, 11, 1, 0, 128'h4444,
                           1, 32'h3018, 11, 1, 0, 1, 128'h4444));
      vecs.push_back(mkVec(0,1,1,1, 32'h3020, 12, 1, 2, 128'h5555,
                           0, 32'h3020, 0, 0, 0, 0, '0));
      vecs.push_back(mkVec(0,0,0,1, 32'h3024, 0, 1, 0, 128'h6666,
                           1, 32'h3024, 0, 1, 0, 0, 128'h6666));
      vecs.push_back(mkVec(0,0,0,0, 32'h3028, 13, 1, 1, 128'h7777,
                           0, 32'h3028, 0, 0, 0, 0, '0));
      vecs.push_back(mkVec(0,0,0,1, 32'h302c, 5, 0, 0, 128'h8888,
                           1, 32'h302c, 5, 0, 0, 0, 128'h8888));
      vecs.push_back(mkVec(1,0,1,1, 32'h3030, 6, 1, 0, 128'h9999,
                           0, 32'h3000, 0, 0, 0, 0, '0));
      vecs.push_back(mkVec(0,0,0,1, 32'h3034, 7, 1, 4, 128'habcd,
                           1, 32'h3034, 7, 1, 3, 0, 128'habcd));
      vecs.push_back(mkVec(1,1,0,1, 32'h3038, 7, 1, 4, 128'hef01,
                           0, 32'h3000, 0, 0, 0, 0, '0));

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].stall,
                       vecs[i].valid, vecs[i].pc, vecs[i].wr,
                       vecs[i].regwrite, vecs[i].tnew, vecs[i].payload);
         checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                     vecs[i].e_wr, vecs[i].e_regwrite, vecs[i].e_tnew,
                     vecs[i].e_fwd, vecs[i].e_payload);
      end

      // ------- hand sequence: flush arriving in the middle of a stall -------
      applyStimulus(0,0,0,1, 32'h3040, 3, 1, 3, 128'h1234);
      checkOutput("seq_load", 1, 32'h3040, 3, 1, 2, 0, 128'h1234);
      for (int c = 0; c < 2; c++) begin
         applyStimulus(0,0,1,1, 32'h3044 + 32'(c), 4, 1, 0, 128'h5678);
         checkOutput($sformatf("seq_hold%0d", c), 1, 32'h3040, 3, 1, 2, 0,
                     128'h1234);
      end
      applyStimulus(0,1,1,1, 32'h3050, 4, 1, 0, 128'h5678);
      checkOutput("seq_flush", 0, 32'h3050, 0, 0, 0, 0, '0);
      applyStimulus(0,0,0,1, 32'h3054, 4, 1, 1, 128'h9abc);
      checkOutput("seq_resume", 1, 32'h3054, 4, 1, 0, 1, 128'h9abc);

`ifdef PIPE_STAGE_EXC_EN
      // ---------------- exception code selection ----------------
      bus.in_exccode = 5'd0; bus.stage_exccode = 5'd12; bus.in_bd = 1'b0;
      applyStimulus(0,0,0,1, 32'h3060, 2, 1, 0, 128'h1);
      checkField("exc_stage_ov", 128'(bus.out_exccode), 128'd12);
      bus.in_exccode = 5'd4; bus.stage_exccode = 5'd12; bus.in_bd = 1'b1;
      applyStimulus(0,0,0,1, 32'h3064, 2, 1, 0, 128'h2);
      checkField("exc_oldest", 128'(bus.out_exccode), 128'd4);
      checkField("exc_bd_load", 128'(bus.out_bd), 128'd1);
      bus.in_exccode = 5'd10; bus.in_bd = 1'b0;
      applyStimulus(0,0,1,1, 32'h3068, 2, 1, 0, 128'h3);
      checkField("exc_hold", 128'(bus.out_exccode), 128'd4);
      checkField("exc_bd_hold", 128'(bus.out_bd), 128'd1);
      bus.in_exccode = 5'd10; bus.in_bd = 1'b1;
      applyStimulus(0,1,0,1, 32'h306c, 2, 1, 0, 128'h4);
      checkField("exc_flush", 128'(bus.out_exccode), 128'd0);
      checkField("exc_flush_bd", 128'(bus.out_bd), 128'd1);
      bus.in_exccode = 5'd0; bus.stage_exccode = 5'd0; bus.in_bd = 1'b0;
`endif

      // ---------------- randomized run against the model ----------------
      modelStep(1,0,0,0, '0, '0, 0, '0, '0);
      applyStimulus(1,0,0,0, '0, '0, 0, '0, '0);
      checkModel("rnd_init");
      for (int n = 0; n < 400; n++) begin
         logic         r_rst, r_fl, r_st, r_va, r_rw;
         logic [31:0]  r_pc;
         logic [4:0]   r_wr;
         logic [2:0]   r_tn;
         logic [127:0] r_pl;
         r_rst = ($urandom_range(0, 31) == 0);
         r_fl  = ($urandom_range(0, 7) == 0);
         r_st  = ($urandom_range(0, 3) == 0);
         r_va  = ($urandom_range(0, 3) != 0);
         r_rw  = 1'($urandom);
         r_pc  = $urandom;
         r_wr  = 5'($urandom_range(0, 31));
         r_tn  = 3'($urandom_range(0, 7));
         r_pl  = {$urandom, $urandom, $urandom, $urandom};
         modelStep(r_rst, r_fl, r_st, r_va, r_pc, r_wr, r_rw, r_tn, r_pl);
         applyStimulus(r_rst, r_fl, r_st, r_va, r_pc, r_wr, r_rw, r_tn, r_pl);
         checkModel($sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
